// File: rtl/iob_nco_cfg_seq.sv
// Configuration sequencer for the NCO: turns one (period_int, period_frac, enable)
// command into the ordered CSR write burst on the NCO's IOb-native CSR port.
module iob_nco_cfg_seq #(
  parameter int ADDR_W           = 4,
  parameter int SOFT_RESET_ADDR  = 0,
  parameter int ENABLE_ADDR      = 1,
  parameter int PERIOD_INT_ADDR  = 4,
  parameter int PERIOD_FRAC_ADDR = 8,
  parameter int TIMEOUT_W        = 8
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              arst_n_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_full_i,
  input  logic              cmd_enable_i,
  input  logic [31:0]       cmd_period_int_i,
  input  logic [31:0]       cmd_period_frac_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              iob_valid_o,
  output logic [ADDR_W-1:0] iob_addr_o,
  output logic [31:0]       iob_wdata_o,
  output logic [3:0]        iob_wstrb_o,
  output logic              iob_rready_o,
  input  logic              iob_ready_i,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SR_SET  = 3'd1,
    SR_CLR  = 3'd2,
    WR_INT  = 3'd3,
    WR_FRAC = 3'd4,
    WR_EN   = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0]    SR_A     = ADDR_W'(SOFT_RESET_ADDR);
  localparam logic [ADDR_W-1:0]    EN_A     = ADDR_W'(ENABLE_ADDR);
  localparam logic [ADDR_W-1:0]    PI_A     = ADDR_W'(PERIOD_INT_ADDR);
  localparam logic [ADDR_W-1:0]    PF_A     = ADDR_W'(PERIOD_FRAC_ADDR);
  localparam logic [TIMEOUT_W-1:0] TO_LIMIT = '1;

  state_t               state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 full_q, full_d;
  logic                 enable_q, enable_d;
  logic [31:0]          pint_q, pint_d;
  logic [31:0]          pfrac_q, pfrac_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 hs;

  // 1-bit CSRs sit in one byte lane of the 32-bit word selected by the low address bits.
  function automatic logic [3:0] bit_strb(input logic [ADDR_W-1:0] a);
    return 4'b0001 << a[1:0];
  endfunction

  function automatic logic [31:0] bit_data(input logic [ADDR_W-1:0] a, input logic v);
    return {31'b0, v} << {a[1:0], 3'b000};
  endfunction

  // CSR port: a write is offered while iob_valid_o=1 with addr/wdata/wstrb held
  // constant; it completes on the clock edge where iob_valid_o && iob_ready_i
  // (and cke_i) are high, and the next write follows without an idle cycle.
  always_comb begin
    iob_valid_o = 1'b0;
    iob_addr_o  = '0;
    iob_wdata_o = '0;
    iob_wstrb_o = '0;
    unique case (state_q)
      SR_SET: begin
        iob_valid_o = 1'b1;
        iob_addr_o  = SR_A;
        iob_wdata_o = bit_data(SR_A, 1'b1);
        iob_wstrb_o = bit_strb(SR_A);
      end
      SR_CLR: begin
        iob_valid_o = 1'b1;
        iob_addr_o  = SR_A;
        iob_wdata_o = bit_data(SR_A, 1'b0);
        iob_wstrb_o = bit_strb(SR_A);
      end
      WR_INT: begin
        iob_valid_o = 1'b1;
        iob_addr_o  = PI_A;
        iob_wdata_o = pint_q;
        iob_wstrb_o = 4'hF;
      end
      WR_FRAC: begin
        iob_valid_o = 1'b1;
        iob_addr_o  = PF_A;
        iob_wdata_o = pfrac_q;
        iob_wstrb_o = 4'hF;
      end
      WR_EN: begin
        iob_valid_o = 1'b1;
        iob_addr_o  = EN_A;
        iob_wdata_o = bit_data(EN_A, enable_q);
        iob_wstrb_o = bit_strb(EN_A);
      end
      default: ;
    endcase
  end

  assign hs = iob_valid_o && iob_ready_i;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    full_d   = full_q;
    enable_d = enable_q;
    pint_d   = pint_q;
    pfrac_d  = pfrac_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    if (state_q == IDLE) begin
      if (cmd_valid_i) begin
        full_d   = cmd_full_i;
        enable_d = cmd_enable_i;
        pint_d   = cmd_period_int_i;
        pfrac_d  = cmd_period_frac_i;
        cnt_d    = '0;
        state_d  = cmd_full_i ? SR_SET : WR_INT;
      end
    end else if (hs) begin
      cnt_d = '0;
      unique case (state_q)
        SR_SET:  state_d = SR_CLR;
        SR_CLR:  state_d = WR_INT;
        WR_INT:  state_d = WR_FRAC;
        WR_FRAC: begin
          state_d = full_q ? WR_EN : IDLE;
          done_d  = !full_q;
        end
        WR_EN: begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (cnt_q == TO_LIMIT) begin
      // Target never answered: abandon the rest of the burst.
      state_d = IDLE;
      cnt_d   = '0;
      err_d   = 1'b1;
    end else begin
      cnt_d = cnt_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      enable_q <= 1'b0;
      pint_q   <= '0;
      pfrac_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (cke_i) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      enable_q <= enable_d;
      pint_q   <= pint_d;
      pfrac_q  <= pfrac_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign cmd_ready_o  = (state_q == IDLE);
  assign busy_o       = !cmd_ready_o;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign iob_rready_o = 1'b1;
  assign dbg_state_o  = state_q;

endmodule
